// File: rtl/xoodyak_host_pkg.sv
// Shared types and constants for the xoodyak word-serial host front end.
// Word indices are 5 bits wide to cover the 22-word decrypt load.
package xoodyak_host_pkg;

    typedef enum logic [1:0] {
        ST_LOAD,
        ST_START,
        ST_WAIT,
        ST_UNLOAD
    } state_t;

    localparam logic [4:0] ENC_WORDS = 5'd18;
    localparam logic [4:0] DEC_WORDS = 5'd22;
    localparam logic [3:0] OUT_WORDS = 4'd11;

    localparam logic [4:0] KEY_W0   = 5'd0;
    localparam logic [4:0] NONCE_W0 = 5'd4;
    localparam logic [4:0] AD_W0    = 5'd8;
    localparam logic [4:0] TEXT_W0  = 5'd12;
    localparam logic [4:0] TAG_W0   = 5'd18;

    localparam int STAT_VERIFY  = 0;
    localparam int STAT_TIMEOUT = 1;

    function automatic logic [4:0] last_word(input logic opmode);
        return opmode ? (DEC_WORDS - 5'd1) : (ENC_WORDS - 5'd1);
    endfunction

endpackage

// File: rtl/xoodyak_host_unload.sv
// Output word mux: six text words, four tag words, then the status word,
// selected by the unload counter.
module xoodyak_host_unload
    import xoodyak_host_pkg::*;
(
    input  logic [191:0] text,
    input  logic [127:0] tag,
    input  logic         timeout,
    input  logic         verify,
    input  logic [3:0]   idx,
    output logic [31:0]  word
);

    logic [5:0][31:0] text_w;
    logic [3:0][31:0] tag_w;

    assign text_w = text;
    assign tag_w  = tag;

    // Indices 6..9 have low bits 2,3,0,1, so subtracting 2 (mod 4) gives tag word 0..3.
    always_comb begin
        word = '0;
        if (idx < 4'd6) begin
            word = text_w[idx[2:0]];
        end else if (idx < 4'd10) begin
            word = tag_w[idx[1:0] - 2'd2];
        end else begin
            word[STAT_VERIFY]  = verify;
            word[STAT_TIMEOUT] = timeout;
        end
    end

endmodule

// File: rtl/xoodyak_host.sv
// Word-serial host for xoodyak_build: loads operands from a 32-bit stream,
// starts the core, and returns text, tag and status on a 32-bit stream.
//
//   state     | meaning
//   ----------|-----------------------------------------------------------
//   ST_LOAD   | accepting operand words; leaves after the last word
//   ST_START  | one-cycle core_start pulse, timeout counter cleared
//   ST_WAIT   | waiting for core_sqzdone or timeout terminal count
//   ST_UNLOAD | emitting 11 result words, then back to ST_LOAD
module xoodyak_host
    import xoodyak_host_pkg::*;
#(
    parameter int TIMEOUT_CLKS = 64
) (
    input  logic         eph1,
    input  logic         reset_n,
    input  logic         in_valid,
    input  logic [31:0]  in_data,
    input  logic         in_opmode,
    output logic         in_ready,
    output logic         out_valid,
    output logic [31:0]  out_data,
    input  logic         out_ready,
    output logic         busy,
    output logic         core_start,
    output logic         core_opmode,
    output logic [127:0] core_key,
    output logic [127:0] core_nonce,
    output logic [127:0] core_assodata,
    output logic [127:0] core_verif,
    output logic [191:0] core_textin,
    input  logic [191:0] core_textout,
    input  logic [127:0] core_authdata,
    input  logic         core_sqzdone,
    input  logic         core_verify
);

    localparam int              TW       = $clog2(TIMEOUT_CLKS) + 1;
    localparam logic [TW-1:0]   TMO_LAST = TW'(TIMEOUT_CLKS - 1);

    state_t           state_q, state_d;
    logic [4:0]       word_cnt_q;
    logic [3:0]       out_cnt_q;
    logic [TW-1:0]    tmo_cnt_q;

    logic             opmode_q;
    logic [3:0][31:0] key_q, nonce_q, ad_q, tag_in_q;
    logic [5:0][31:0] text_in_q;

    logic [191:0]     text_cap_q;
    logic [127:0]     tag_cap_q;
    logic             verify_q, timeout_q;

    logic             in_acc, out_acc, last_in, last_out, capture, expire;
    logic [2:0]       text_rel;
    logic [1:0]       tag_rel;

    assign in_ready   = (state_q == ST_LOAD);
    assign out_valid  = (state_q == ST_UNLOAD);
    assign core_start = (state_q == ST_START);
    assign busy       = !((state_q == ST_LOAD) && (word_cnt_q == '0));

    assign in_acc   = in_valid & in_ready;
    assign out_acc  = out_valid & out_ready;
    // Word 0 carries the mode for the current load, so use the live input there.
    assign last_in  = word_cnt_q == last_word((word_cnt_q == KEY_W0) ? in_opmode : opmode_q);
    assign last_out = out_cnt_q == (OUT_WORDS - 4'd1);
    assign capture  = (state_q == ST_WAIT) && core_sqzdone;
    assign expire   = (state_q == ST_WAIT) && !core_sqzdone && (tmo_cnt_q == TMO_LAST);

    assign text_rel = 3'(word_cnt_q - TEXT_W0);
    assign tag_rel  = 2'(word_cnt_q - TAG_W0);

    always_ff @(posedge eph1 or negedge reset_n) begin
        if (!reset_n) state_q <= ST_LOAD;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_LOAD:   if (in_acc && last_in)   state_d = ST_START;
            ST_START:                           state_d = ST_WAIT;
            ST_WAIT:   if (capture || expire)   state_d = ST_UNLOAD;
            ST_UNLOAD: if (out_acc && last_out) state_d = ST_LOAD;
            default:                            state_d = ST_LOAD;
        endcase
    end

    always_ff @(posedge eph1 or negedge reset_n) begin
        if (!reset_n) begin
            word_cnt_q <= '0;
            out_cnt_q  <= '0;
            tmo_cnt_q  <= '0;
        end else begin
            if (in_acc)  word_cnt_q <= last_in ? 5'd0 : word_cnt_q + 5'd1;
            if (out_acc) out_cnt_q  <= last_out ? 4'd0 : out_cnt_q + 4'd1;
            if (state_q == ST_START)     tmo_cnt_q <= '0;
            else if (state_q == ST_WAIT) tmo_cnt_q <= tmo_cnt_q + TW'(1);
        end
    end

    // Operands only change on accepted words, so they are frozen through WAIT.
    always_ff @(posedge eph1 or negedge reset_n) begin
        if (!reset_n) begin
            opmode_q  <= 1'b0;
            key_q     <= '0;
            nonce_q   <= '0;
            ad_q      <= '0;
            text_in_q <= '0;
            tag_in_q  <= '0;
        end else if (in_acc) begin
            if (word_cnt_q == KEY_W0) opmode_q <= in_opmode;
            if (word_cnt_q < NONCE_W0)     key_q[word_cnt_q[1:0]]   <= in_data;
            else if (word_cnt_q < AD_W0)   nonce_q[word_cnt_q[1:0]] <= in_data;
            else if (word_cnt_q < TEXT_W0) ad_q[word_cnt_q[1:0]]    <= in_data;
            else if (word_cnt_q < TAG_W0)  text_in_q[text_rel]      <= in_data;
            else                           tag_in_q[tag_rel]        <= in_data;
        end
    end

    always_ff @(posedge eph1 or negedge reset_n) begin
        if (!reset_n) begin
            text_cap_q <= '0;
            tag_cap_q  <= '0;
            verify_q   <= 1'b0;
            timeout_q  <= 1'b0;
        end else if (capture) begin
            text_cap_q <= core_textout;
            tag_cap_q  <= core_authdata;
            verify_q   <= core_verify;
            timeout_q  <= 1'b0;
        end else if (expire) begin
            text_cap_q <= '0;
            tag_cap_q  <= '0;
            verify_q   <= 1'b0;
            timeout_q  <= 1'b1;
        end
    end

    assign core_opmode   = opmode_q;
    assign core_key      = key_q;
    assign core_nonce    = nonce_q;
    assign core_assodata = ad_q;
    assign core_textin   = text_in_q;
    assign core_verif    = tag_in_q;

    xoodyak_host_unload u_unload (
        .text    (text_cap_q),
        .tag     (tag_cap_q),
        .timeout (timeout_q),
        .verify  (verify_q),
        .idx     (out_cnt_q),
        .word    (out_data)
    );

endmodule

// File: tb/tb_xoodyak_host.sv
// Bench for xoodyak_host: a stub core with a toy cipher, a table of operations
// (fixed plus random) and hand-written reset sequences.
module tb_xoodyak_host;

    localparam int TMO = 64;

    logic         eph1, reset_n;
    logic         in_valid, in_opmode, in_ready;
    logic [31:0]  in_data;
    logic         out_valid, out_ready;
    logic [31:0]  out_data;
    logic         busy, core_start, core_opmode;
    logic [127:0] core_key, core_nonce, core_assodata, core_verif, core_authdata;
    logic [191:0] core_textin, core_textout;
    logic         core_sqzdone, core_verify;

    xoodyak_host #(.TIMEOUT_CLKS(TMO)) dut (
        .eph1(eph1), .reset_n(reset_n),
        .in_valid(in_valid), .in_data(in_data), .in_opmode(in_opmode), .in_ready(in_ready),
        .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
        .busy(busy), .core_start(core_start), .core_opmode(core_opmode),
        .core_key(core_key), .core_nonce(core_nonce), .core_assodata(core_assodata),
        .core_verif(core_verif), .core_textin(core_textin), .core_textout(core_textout),
        .core_authdata(core_authdata), .core_sqzdone(core_sqzdone), .core_verify(core_verify)
    );

    initial eph1 = 1'b0;
    always #5 eph1 = ~eph1;

    typedef struct {
        bit           mode;
        logic [127:0] key, nonce, ad, tag;
        logic [191:0] text;
        int           lat;      // stub start-to-sqzdone latency, 0 = never
        bit           stall;
        logic [31:0]  st;       // required status word
    } op_t;

    int n_chk = 0, n_pass = 0;
    int cyc = 0, n_start = 0, n_outv = 0, start_cyc = 0;
    int last_acc = 0, first_ov = 0;
    int stub_lat = 0, stub_cnt;

    function automatic logic [191:0] ks_f(logic [127:0] k, logic [127:0] n, logic [127:0] a);
        return {k ^ {n[63:0], n[127:64]}, a[95:32] ^ 64'h0123456789abcdef};
    endfunction

    function automatic logic [127:0] tag_f(logic [127:0] k, logic [127:0] n, logic [127:0] a,
                                           logic [191:0] p);
        return k ^ n ^ {a[63:0], a[127:64]} ^ p[127:0] ^ {p[191:128], p[191:128]};
    endfunction

    // Stub core: toy stream cipher plus tag, sqzdone after stub_lat cycles.
    logic [191:0] stub_ks, stub_pt;
    always_comb begin
        stub_ks       = ks_f(core_key, core_nonce, core_assodata);
        stub_pt       = core_opmode ? (core_textin ^ stub_ks) : core_textin;
        core_textout  = core_textin ^ stub_ks;
        core_authdata = tag_f(core_key, core_nonce, core_assodata, stub_pt);
        core_verify   = core_opmode && (core_authdata == core_verif);
    end

    always @(posedge eph1 or negedge reset_n) begin
        if (!reset_n)              stub_cnt <= 0;
        else if (core_start)       stub_cnt <= stub_lat;
        else if (stub_cnt != 0)    stub_cnt <= stub_cnt - 1;
    end
    assign core_sqzdone = (stub_cnt == 1);

    always @(posedge eph1) cyc <= cyc + 1;

    always @(negedge eph1) begin
        if (core_start) begin
            n_start   <= n_start + 1;
            start_cyc <= cyc;
        end
        if (out_valid) n_outv <= n_outv + 1;
    end

    task automatic chk(input string name, input logic [191:0] act, input logic [191:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, want %0h", name, act, exp);
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    function automatic op_t mk(bit mode, logic [127:0] k, logic [127:0] n, logic [127:0] a,
                               logic [191:0] pt, int lat, bit stall, bit tamper, logic [31:0] st);
        op_t r;
        r.mode = mode; r.key = k; r.nonce = n; r.ad = a;
        r.lat = lat; r.stall = stall; r.st = st;
        if (mode) begin
            r.text = pt ^ ks_f(k, n, a);
            r.tag  = tag_f(k, n, a, pt) ^ {127'b0, tamper};
        end else begin
            r.text = pt;
            r.tag  = '0;
        end
        return r;
    endfunction

    function automatic bit is_tmo(input op_t r);
        return (r.lat == 0) || (r.lat > TMO);
    endfunction

    // Expected output stream: result text, tag, then status (or zeros on timeout).
    function automatic void model(input op_t r, output logic [31:0] e[11]);
        logic [191:0] res;
        logic [127:0] t;
        res = r.text ^ ks_f(r.key, r.nonce, r.ad);
        t   = tag_f(r.key, r.nonce, r.ad, r.mode ? res : r.text);
        for (int i = 0; i < 6; i++) e[i]     = is_tmo(r) ? 32'h0 : res[32*i +: 32];
        for (int i = 0; i < 4; i++) e[6 + i] = is_tmo(r) ? 32'h0 : t[32*i +: 32];
        e[10] = r.st;
    endfunction

    function automatic void words_of(input op_t r, output logic [31:0] w[22]);
        for (int i = 0; i < 4; i++) begin
            w[i]      = r.key[32*i +: 32];
            w[4 + i]  = r.nonce[32*i +: 32];
            w[8 + i]  = r.ad[32*i +: 32];
            w[18 + i] = r.tag[32*i +: 32];
        end
        for (int i = 0; i < 6; i++) w[12 + i] = r.text[32*i +: 32];
    endfunction

    task automatic load_words(input op_t r, input int idx);
        logic [31:0] w[22];
        int n, i, guard;
        words_of(r, w);
        n = r.mode ? 22 : 18;
        i = 0;
        guard = 0;
        while (i < n && guard < 500) begin
            @(negedge eph1);
            in_valid  = r.stall ? 1'($urandom_range(0, 1)) : 1'b1;
            in_data   = w[i];
            in_opmode = r.mode;
            if (in_valid && in_ready) begin
                i++;
                last_acc = cyc;
            end
            guard++;
        end
        @(posedge eph1);
        #1 in_valid = 1'b0;
        if (i < n) chk($sformatf("op%0d_load_bound", idx), 192'(i), 192'(n));
    endtask

    task automatic collect(input op_t r, input int idx, input logic [31:0] e[11]);
        int k, guard, bad_stall, bad_flags;
        bit prev_stall;
        logic [31:0] prev;
        k = 0; guard = 0; bad_stall = 0; bad_flags = 0;
        prev_stall = 0; prev = '0; first_ov = -1;
        while (k < 11 && guard < 2000) begin
            @(negedge eph1);
            out_ready = r.stall ? 1'($urandom_range(0, 1)) : 1'b1;
            if (in_ready || !busy) bad_flags++;
            if (out_valid) begin
                if (first_ov < 0) first_ov = cyc;
                if (prev_stall && out_data !== prev) bad_stall++;
                if (out_ready) begin
                    chk($sformatf("op%0d_word%0d", idx, k), 192'(out_data), 192'(e[k]));
                    k++;
                    prev_stall = 0;
                end else begin
                    prev_stall = 1;
                    prev = out_data;
                end
            end
            guard++;
        end
        if (k < 11) chk($sformatf("op%0d_unload_bound", idx), 192'(k), 192'd11);
        chk($sformatf("op%0d_stall_stable", idx), 192'(bad_stall), 192'd0);
        chk($sformatf("op%0d_busy_in_ready", idx), 192'(bad_flags), 192'd0);
        @(negedge eph1);
        out_ready = 1'b0;
        chk($sformatf("op%0d_reentry_ready", idx), 192'(in_ready), 192'd1);
        chk($sformatf("op%0d_reentry_idle", idx), 192'(busy), 192'd0);
    endtask

    task automatic run_op(input op_t r, input int idx);
        logic [31:0] e[11];
        int s0;
        s0 = n_start;
        model(r, e);
        stub_lat = r.lat;
        load_words(r, idx);
        if (idx == 0) begin
            chk("op0_core_key", 192'(core_key), 192'(128'h3f3e3d3c_3b3a3938_37363534_33323130));
            chk("op0_core_textin", core_textin, r.text);
            chk("op0_core_opmode", 192'(core_opmode), 192'd0);
        end
        collect(r, idx, e);
        chk($sformatf("op%0d_start_pulses", idx), 192'(n_start - s0), 192'd1);
        chk($sformatf("op%0d_start_delay", idx), 192'(start_cyc - last_acc), 192'd1);
        chk($sformatf("op%0d_first_out", idx), 192'(first_ov - start_cyc),
            192'(is_tmo(r) ? TMO + 1 : r.lat + 1));
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got running, want done");
        $fatal(1);
    end

    op_t          tbl[20];
    logic [127:0] k0, n0, a0;
    logic [191:0] pt0;
    logic [31:0]  w0[22];
    op_t          rw;
    int           s0, v0, lat_r;
    bit           m_r, tp_r;

    initial begin
        reset_n = 1'b1; in_valid = 1'b0; in_data = '0; in_opmode = 1'b0; out_ready = 1'b0;
        #3 reset_n = 1'b0;
        repeat (3) @(posedge eph1);
        #1;
        chk("rst_in_ready",  192'(in_ready),    192'd1);
        chk("rst_out_valid", 192'(out_valid),   192'd0);
        chk("rst_start",     192'(core_start),  192'd0);
        chk("rst_busy",      192'(busy),        192'd0);
        chk("rst_opmode",    192'(core_opmode), 192'd0);
        chk("rst_key",       192'(core_key),    192'd0);
        chk("rst_textin",    core_textin,       192'd0);
        chk("rst_verif",     192'(core_verif),  192'd0);
        @(negedge eph1) reset_n = 1'b1;

        k0  = 128'h3f3e3d3c_3b3a3938_37363534_33323130;
        n0  = 128'h504f4e4d_4c4b4a49_48474645_44434241;
        a0  = 128'h706f6e6d_6c6b6a69_68676665_64636261;
        pt0 = {32'h58575655, 32'h54535251, 32'h504f4e4d,
               32'h4c4b4a49, 32'h48474645, 32'h44434241};

        tbl[0] = mk(0, k0, n0, a0, pt0, 5,  0, 0, 32'h0);
        tbl[1] = mk(1, k0, n0, a0, pt0, 5,  0, 0, 32'h1);
        tbl[2] = mk(1, k0, n0, a0, pt0, 5,  0, 1, 32'h0);
        tbl[3] = mk(0, k0, n0, a0, pt0, 0,  0, 0, 32'h2);
        tbl[4] = mk(0, k0, n0, a0, pt0, 64, 0, 0, 32'h0);
        tbl[5] = mk(0, k0, n0, a0, pt0, 65, 0, 0, 32'h2);
        tbl[6] = mk(0, k0, n0, a0, pt0, 5,  1, 0, 32'h0);
        tbl[7] = mk(1, k0, n0, a0, pt0, 64, 1, 0, 32'h1);
        for (int i = 8; i < 20; i++) begin
            m_r   = 1'($urandom_range(0, 1));
            tp_r  = ($urandom_range(0, 3) == 0);
            lat_r = $urandom_range(1, 70);
            tbl[i] = mk(m_r, rnd128(), rnd128(), rnd128(), {rnd128(), $urandom, $urandom},
                        lat_r, 1'($urandom_range(0, 1)), tp_r,
                        (lat_r > TMO) ? 32'h2 : ((m_r && !tp_r) ? 32'h1 : 32'h0));
        end

        for (int i = 0; i < 20; i++) run_op(tbl[i], i);

        // Reset while word 9 is on the bus.
        s0 = n_start; v0 = n_outv; stub_lat = 5;
        words_of(tbl[0], w0);
        for (int i = 0; i < 9; i++) begin
            @(negedge eph1);
            in_valid = 1'b1; in_data = w0[i]; in_opmode = 1'b0;
        end
        @(negedge eph1);
        in_data = w0[9];
        reset_n = 1'b0;
        #1;
        chk("rst_load_busy",  192'(busy),     192'd0);
        chk("rst_load_ready", 192'(in_ready), 192'd1);
        chk("rst_load_key",   192'(core_key), 192'd0);
        @(negedge eph1);
        in_valid = 1'b0;
        reset_n = 1'b1;
        repeat (30) @(negedge eph1);
        chk("rst_load_no_start", 192'(n_start - s0), 192'd0);
        chk("rst_load_no_out",   192'(n_outv - v0),  192'd0);
        run_op(tbl[0], 20);

        // Reset while waiting on the core.
        rw = tbl[0];
        rw.lat = 30;
        stub_lat = 30;
        s0 = n_start; v0 = n_outv;
        load_words(rw, 21);
        repeat (5) @(negedge eph1);
        reset_n = 1'b0;
        #1;
        chk("rst_wait_busy",  192'(busy),     192'd0);
        chk("rst_wait_ready", 192'(in_ready), 192'd1);
        @(negedge eph1) reset_n = 1'b1;
        repeat (40) @(negedge eph1);
        chk("rst_wait_one_start", 192'(n_start - s0), 192'd1);
        chk("rst_wait_no_out",    192'(n_outv - v0),  192'd0);
        run_op(tbl[1], 22);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/xoodyak_host.md
# xoodyak_host

Word-serial host front end for `xoodyak_build`. It accepts operands on a 32-bit valid/ready input stream, assembles the 128-bit key, nonce and associated data, the 192-bit text and the optional tag, and pulses the core start. It then waits for `sqzdone` and returns text, tag and status on a 32-bit valid/ready output stream. It is the bus-facing counterpart of the core: it produces the core's inputs and consumes its outputs.

## Interface
- `TIMEOUT_CLKS`, default 64: number of WAIT cycles without `core_sqzdone` before the operation is aborted.
- `eph1` in 1: clock; all flops rise on `eph1`.
- `reset_n` in 1: asynchronous, active-low reset.
- `in_valid` in 1: input word valid.
- `in_data` in 32: input word.
- `in_opmode` in 1: 0 = encrypt, 1 = decrypt; sampled only when word 0 is accepted.
- `in_ready` out 1: block can accept a word.
- `out_valid` out 1: output word valid.
- `out_data` out 32: output word.
- `out_ready` in 1: downstream accepts the word.
- `busy` out 1: high in every state except LOAD with word count 0.
- `core_start` out 1: one-cycle start pulse to the core.
- `core_opmode` out 1: registered operating mode.
- `core_key`, `core_nonce`, `core_assodata` out 128 each: registered operands.
- `core_verif` out 128: registered tag operand.
- `core_textin` out 192: registered text operand.
- `core_textout` in 192: text result from the core.
- `core_authdata` in 128: tag result from the core.
- `core_sqzdone` in 1: core results valid.
- `core_verify` in 1: tag match, meaningful in decrypt mode.

## Operation
- States: LOAD, START, WAIT, UNLOAD.
- Input word order:
  - words 0-3: key
  - words 4-7: nonce
  - words 8-11: associated data
  - words 12-17: text
  - words 18-21: tag, decrypt only
- Within each field, the lower word index fills the lower bits; word 0 → `core_key[31:0]`.
- Input length: encrypt is 18 words; decrypt is 22 words.
- LOAD:
  - `in_ready`=1; a word is accepted when `in_valid & in_ready`.
  - On acceptance, write the word to its field and increment the word count.
  - The last accepted word moves to START. The count clears to 0.
- START:
  - `core_start`=1 for exactly this cycle, then WAIT.
  - Clear the timeout counter.
- WAIT:
  - Counter increments each cycle.
  - If `core_sqzdone`=1, capture `core_textout`, `core_authdata` and `core_verify`; set timeout flag=0; go to UNLOAD.
  - Else, if the counter equals `TIMEOUT_CLKS`-1, zero the captured text and tag, set timeout flag=1, and go to UNLOAD.
  - If `sqzdone` and the terminal count occur together, `sqzdone` wins.
- UNLOAD emits 11 words in this order:
  - text words 0-5, low word first
  - tag words 0-3
  - status word: {30'b0, timeout, verify}
- UNLOAD handshake and exit:
  - `out_data` is stable while `out_valid & ~out_ready`.
  - After the status word is accepted, go to LOAD.
- Operand registers hold their values from LOAD exit until the next accepted word 0. Core inputs are stable throughout WAIT.
- `core_sqzdone` outside WAIT is ignored.
- `in_ready`=0 outside LOAD.
- `out_valid`=0 outside UNLOAD.

## Timing
- Reset values:
  - state LOAD, word count 0
  - all operand and capture registers 0
  - `in_ready`=1, `out_valid`=0, `core_start`=0, `busy`=0, `core_opmode`=0
- Reset mid-operation aborts immediately: no start pulse or output word follows.
- Input: one word per cycle maximum. With `in_valid` held high, an encrypt load takes 18 cycles; START follows on the next cycle.
- `core_start` rises one cycle after the last input word is accepted.
- Capture happens on the `eph1` edge where `core_sqzdone`=1. `out_valid` rises the following cycle.
- Output: one word per cycle maximum. With `out_ready` held high, the 11 words take 11 cycles.
- LOAD re-entry has `in_ready`=1 in the cycle after the status word is accepted.
- Total for encrypt with no stalls and core latency L cycles (start to sqzdone): 18 + 1 + L + 11.

## Structure
- Package `xoodyak_host_pkg` holds:
  - state enum
  - `ENC_WORDS`=18, `DEC_WORDS`=22, `OUT_WORDS`=11
  - field base indices: `KEY_W0`=0, `NONCE_W0`=4, `AD_W0`=8, `TEXT_W0`=12, `TAG_W0`=18
  - status bit positions
- One sub-module, `xoodyak_host_unload`: a word mux over the captured 192+128+2 bits, indexed by the output counter.
- Operand registers, counters and the FSM live in the top module.

## Test plan
- Encrypt load:
  - Stimulus: key 0x33323130,0x37363534,0x3b3a3938,0x3f3e3d3c; nonce 0x44434241,…; AD 0x64636261,…; text "ABCDEFGHIJKLMNOPQRSTUVWX"; stub core returns sqzdone 5 cycles after start.
  - Required: `core_key`=128'h3f3e3d3c3b3a393837363534333231 30; exactly one `core_start` pulse; 11 output words; status=0.
- Decrypt round trip with a real `xoodyak_build`:
  - Stimulus: feed the encrypt ciphertext and tag back as a decrypt operation.
  - Required: returned text equals the plaintext; status=32'h1.
- Tampered tag:
  - Stimulus: decrypt with tag word 0 XOR 1.
  - Required: status=32'h0.
- Timeout:
  - Stimulus: stub core never asserts sqzdone; `TIMEOUT_CLKS`=64.
  - Required: `out_valid` rises 65 cycles after start; 10 zero words; status=32'h2.
- Back-pressure:
  - Stimulus: random `in_valid`/`out_ready` at 50%.
  - Required: same data as the no-stall run; `out_data` stable while stalled.
- Reset mid-operation:
  - Stimulus: `reset_n` low during word 9 of a load, and separately during WAIT.
  - Required: no `core_start`, no `out_valid`; the next full load operates normally.
